// File: rtl/tile_map_writer.sv
// tile_map_writer: expands write/fill/block draw commands into one tile RAM write per cycle
module tile_map_writer #(
  parameter int RAM_DATA_WIDTH = 7,
  parameter int RAM_ADDR_WIDTH = 9,
  parameter int MAP_COLS = 20,
  parameter int MAP_ROWS = 15,
  parameter int BLK_W = 4,
  parameter int BLK_H = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      cmd_valid_i,
  output logic                      cmd_ready_o,
  input  logic [1:0]                cmd_op_i,
  input  logic [RAM_ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [RAM_DATA_WIDTH-1:0] cmd_data_i,
  output logic                      ram_we_o,
  output logic [RAM_ADDR_WIDTH-1:0] ram_addr_o,
  output logic [RAM_DATA_WIDTH-1:0] ram_data_o,
  output logic                      done_o,
  output logic                      err_o
);
  localparam logic [2:0] S_IDLE = 3'd0, S_WRITE = 3'd1, S_FILL = 3'd2, S_BLOCK = 3'd3, S_ERR = 3'd4;
  localparam int N = MAP_COLS * MAP_ROWS;
  localparam int LW = $clog2(N + 1);
  localparam int CW = $clog2(BLK_W + 1);
  localparam logic [RAM_ADDR_WIDTH-1:0] A_N = RAM_ADDR_WIDTH'(N);
  localparam logic [RAM_ADDR_WIDTH-1:0] A_COLS = RAM_ADDR_WIDTH'(MAP_COLS);
  localparam logic [RAM_ADDR_WIDTH-1:0] A_ROWS = RAM_ADDR_WIDTH'(MAP_ROWS);
  localparam logic [RAM_ADDR_WIDTH-1:0] A_BW = RAM_ADDR_WIDTH'(BLK_W);
  localparam logic [RAM_ADDR_WIDTH-1:0] A_BH = RAM_ADDR_WIDTH'(BLK_H);
  localparam logic [RAM_ADDR_WIDTH-1:0] A_STEP = RAM_ADDR_WIDTH'(MAP_COLS - BLK_W + 1);
  localparam logic [RAM_ADDR_WIDTH-1:0] A_ONE = RAM_ADDR_WIDTH'(1);
  localparam logic [RAM_DATA_WIDTH-1:0] D_ONE = RAM_DATA_WIDTH'(1);
  localparam logic [LW-1:0] L_FILL = LW'(N - 1);
  localparam logic [LW-1:0] L_BLK = LW'(BLK_W * BLK_H - 1);
  localparam logic [LW-1:0] L_ONE = LW'(1);
  localparam logic [CW-1:0] C_LAST = CW'(BLK_W - 1);
  localparam logic [CW-1:0] C_ONE = CW'(1);
  logic [2:0] state;
  logic [LW-1:0] left;
  logic [CW-1:0] c;
  logic [RAM_ADDR_WIDTH-1:0] col, row;
  logic in_map, blk_ok, ok;
  logic [LW-1:0] left_init;
  assign col = cmd_addr_i % A_COLS;
  assign row = cmd_addr_i / A_COLS;
  assign in_map = cmd_addr_i < A_N;
  assign blk_ok = in_map && (col + A_BW <= A_COLS) && (row + A_BH <= A_ROWS);
  assign ok = cmd_op_i == 2'b00 ? in_map : cmd_op_i == 2'b01 ? 1'b1 : cmd_op_i == 2'b10 ? blk_ok : 1'b0;
  assign left_init = cmd_op_i == 2'b00 ? '0 : cmd_op_i == 2'b01 ? L_FILL : L_BLK;
  assign cmd_ready_o = state == S_IDLE && rst_ni;
  // left counts writes still to come after the one on the outputs; 0 means this is the last
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state <= S_IDLE;
      ram_we_o <= 1'b0;
      ram_addr_o <= '0;
      ram_data_o <= '0;
      done_o <= 1'b0;
      err_o <= 1'b0;
      left <= '0;
      c <= '0;
    end else if (state == S_IDLE) begin
      if (cmd_valid_i && !ok) begin
        state <= S_ERR;
        err_o <= 1'b1;
        left <= '0;
      end else if (cmd_valid_i) begin
        state <= cmd_op_i == 2'b00 ? S_WRITE : cmd_op_i == 2'b01 ? S_FILL : S_BLOCK;
        ram_we_o <= 1'b1;
        ram_addr_o <= cmd_op_i == 2'b01 ? '0 : cmd_addr_i;
        ram_data_o <= cmd_data_i;
        done_o <= left_init == '0;
        left <= left_init;
        c <= '0;
      end
    end else if (left == '0) begin
      state <= S_IDLE;
      ram_we_o <= 1'b0;
      done_o <= 1'b0;
      err_o <= 1'b0;
    end else begin
      left <= left - L_ONE;
      done_o <= left == L_ONE;
      c <= c == C_LAST ? '0 : c + C_ONE;
      ram_addr_o <= state == S_BLOCK && c == C_LAST ? ram_addr_o + A_STEP : ram_addr_o + A_ONE;
      ram_data_o <= state == S_BLOCK ? ram_data_o + D_ONE : ram_data_o;
    end
  end
endmodule

// File: tb/tb_tile_map_writer.sv
// tb_tile_map_writer: random and directed draw commands against a queue-based reference of expected RAM writes
module tb_tile_map_writer;
  logic clk = 0, rst_ni = 0, cmd_valid_i = 0;
  logic cmd_ready_o;
  logic [1:0] cmd_op_i = 0;
  logic [8:0] cmd_addr_i = 0;
  logic [6:0] cmd_data_i = 0;
  logic ram_we_o, done_o, err_o;
  logic [8:0] ram_addr_o;
  logic [6:0] ram_data_o;
  int checks = 0, errors = 0;
  typedef struct {bit err; int addr; int data; bit done;} ev_t;
  ev_t q[$];

  tile_map_writer dut (
    .clk_i(clk), .rst_ni(rst_ni), .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_op_i(cmd_op_i), .cmd_addr_i(cmd_addr_i), .cmd_data_i(cmd_data_i),
    .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o), .ram_data_o(ram_data_o),
    .done_o(done_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
    end
  endtask

  // Reference: list every write (or the error pulse) a command must produce; n is the ready-low length
  task automatic model(input int op, input int a, input int d, output int n);
    ev_t e;
    n = 0;
    if (op == 0 && a < 300) begin
      e = '{0, a, d % 128, 1}; q.push_back(e); n = 1;
    end else if (op == 1) begin
      for (int i = 0; i < 300; i++) begin e = '{0, i, d % 128, i == 299}; q.push_back(e); end
      n = 300;
    end else if (op == 2 && a < 300 && a % 20 + 4 <= 20 && a / 20 + 4 <= 15) begin
      for (int r = 0; r < 4; r++)
        for (int k = 0; k < 4; k++) begin
          e = '{0, a + r * 20 + k, (d + r * 4 + k) % 128, r == 3 && k == 3};
          q.push_back(e);
        end
      n = 16;
    end else begin
      e = '{1, 0, 0, 0}; q.push_back(e); n = 1;
    end
  endtask

  always @(negedge clk) begin
    if (done_o && err_o) chk("done_err_overlap", 1, 0);
    if (done_o && !ram_we_o) chk("done_without_we", int'(ram_we_o), 1);
    if (ram_we_o || err_o) begin
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_out: we=%0b err=%0b addr=%0d data=%0d, none expected", ram_we_o, err_o, ram_addr_o, ram_data_o);
      end else begin
        ev_t e;
        e = q.pop_front();
        chk("err_o", int'(err_o), int'(e.err));
        chk("ram_we_o", int'(ram_we_o), int'(!e.err));
        chk("done_o", int'(done_o), int'(e.done));
        if (!e.err) begin
          chk("ram_addr_o", int'(ram_addr_o), e.addr);
          chk("ram_data_o", int'(ram_data_o), e.data);
        end
      end
    end
  end

  task automatic send(input int op, input int a, input int d, input bit hold);
    int n, k;
    k = 0;
    while (!cmd_ready_o && k < 1000) begin k++; @(negedge clk); end
    chk("ready_wait_bound", int'(k < 1000), 1);
    cmd_op_i = op[1:0]; cmd_addr_i = a[8:0]; cmd_data_i = d[6:0]; cmd_valid_i = 1;
    model(op, a, d, n);
    @(posedge clk); #1;
    if (!hold) cmd_valid_i = 0;
    @(negedge clk);
    chk("first_out_latency", int'({err_o, ram_we_o}), q.size() > 0 && q[0].err ? 2 : 1);
    k = 0;
    while (!cmd_ready_o && k < 1000) begin
      k++;
      if (hold) begin
        cmd_op_i = 2'($urandom); cmd_addr_i = 9'($urandom); cmd_data_i = 7'($urandom);
      end
      @(negedge clk);
    end
    chk("ready_low_cycles", k, n);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int op, a;
    repeat (3) @(negedge clk);
    chk("rst_ready", int'(cmd_ready_o), 0);
    chk("rst_we", int'(ram_we_o), 0);
    chk("rst_addr", int'(ram_addr_o), 0);
    chk("rst_data", int'(ram_data_o), 0);
    chk("rst_done_err", int'({done_o, err_o}), 0);
    rst_ni = 1;
    #1 chk("ready_after_rst", int'(cmd_ready_o), 1);
    @(negedge clk);
    send(0, 5, 'h12, 0);
    send(1, 0, 'h03, 0);
    send(2, 21, 10, 0);
    send(2, 21, 'h7E, 0);
    send(2, 17, 1, 0);
    send(2, 240, 1, 0);
    send(0, 300, 1, 0);
    send(3, 0, 0, 0);
    send(2, 276, 1, 0);
    send(2, 16, 2, 0);
    send(2, 224, 3, 0);
    send(0, 299, 'h7F, 0);
    // abort a fill after its 100th write
    cmd_op_i = 1; cmd_data_i = 3; cmd_valid_i = 1;
    for (int i = 0; i < 100; i++) q.push_back('{0, i, 3, 0});
    @(posedge clk); #1 cmd_valid_i = 0;
    repeat (100) @(negedge clk);
    rst_ni = 0;
    @(negedge clk);
    chk("abort_we", int'(ram_we_o), 0);
    chk("abort_ready", int'(cmd_ready_o), 0);
    chk("abort_done", int'(done_o), 0);
    rst_ni = 1;
    #1 chk("ready_after_abort", int'(cmd_ready_o), 1);
    chk("abort_queue_drained", q.size(), 0);
    send(0, 0, 1, 0);
    send(2, 42, 5, 1);
    send(0, 7, 9, 1);
    send(2, 0, 'h70, 0);
    for (int i = 0; i < 40; i++) begin
      op = $urandom_range(0, 3);
      if (op == 1 && $urandom_range(0, 3) != 0) op = 2;
      a = $urandom_range(0, 3) == 0 ? $urandom_range(0, 511) : $urandom_range(0, 299);
      send(op, a, $urandom_range(0, 127), i < 39 ? 1'($urandom) : 1'b0);
    end
    repeat (5) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/tile_map_writer.md
Name: tile_map_writer

Overview:
- Write-side master of the tile RAM; the pixel drawer is the read side and scans tile addresses 0..299.
- Accepts draw commands from game logic over a valid/ready handshake and expands each command into a sequence of single-cycle tile RAM writes.
- Three commands: single tile write, full-screen fill, and block draw. A block draw places a BLK_W x BLK_H glyph built from consecutive tile types, such as an X or O mark in a board cell.

Parameters:
- RAM_DATA_WIDTH, 7, tile type width (tile RAM data width).
- RAM_ADDR_WIDTH, 9, tile RAM address width.
- MAP_COLS, 20, tiles per screen row.
- MAP_ROWS, 15, tile rows per screen; the map has MAP_COLS*MAP_ROWS = 300 entries.
- BLK_W, 4, block draw width in tiles.
- BLK_H, 4, block draw height in tiles.

Ports:
- clk_i, input, 1, system clock.
- rst_ni, input, 1, synchronous active-low reset.
- cmd_valid_i, input, 1, command valid.
- cmd_ready_o, output, 1, block can accept a command.
- cmd_op_i, input, 2, opcode: 00 WRITE, 01 FILL, 10 BLOCK, 11 reserved.
- cmd_addr_i, input, RAM_ADDR_WIDTH, tile address (WRITE) or top-left tile address (BLOCK); ignored for FILL.
- cmd_data_i, input, RAM_DATA_WIDTH, tile type (WRITE/FILL) or base tile type (BLOCK).
- ram_we_o, output, 1, tile RAM write enable.
- ram_addr_o, output, RAM_ADDR_WIDTH, tile RAM write address.
- ram_data_o, output, RAM_DATA_WIDTH, tile RAM write data.
- done_o, output, 1, one-cycle pulse, coincident with the last write of a command.
- err_o, output, 1, one-cycle pulse for a rejected command.

Behaviour:
- Clock and reset: one clock domain. Reset is synchronous and active-low, sampled at posedge clk_i.
- While rst_ni is low:
  - state goes to IDLE;
  - ram_we_o, ram_addr_o, ram_data_o, done_o and err_o are all 0;
  - cmd_ready_o is 0.
- States: IDLE, WRITE, FILL, BLOCK, ERR.
- Ready rule: cmd_ready_o = (state == IDLE) && rst_ni.
- Handshake: a command is accepted on a clock edge where cmd_valid_i && cmd_ready_o.
  - Inputs are sampled only at acceptance; later changes have no effect.
  - cmd_valid_i may be asserted or held at any time; no command is accepted while busy.
- Latency: the first write appears on ram_*_o in the cycle after acceptance. All outputs are registered.
- Write pacing: exactly one write per cycle with no gaps. The state returns to IDLE on the edge after the last write, so cmd_ready_o is low for exactly N cycles for an N-write command.
- Back-to-back: a new command can be accepted on the edge that ends the previous command's last write cycle plus one, i.e. no dead cycle beyond the ready-low window.
- Address decode at acceptance: col = cmd_addr_i mod MAP_COLS, row = cmd_addr_i / MAP_COLS.
- Validity checks (performed at acceptance):
  - WRITE is invalid if cmd_addr_i >= 300.
  - BLOCK is invalid if cmd_addr_i >= 300, or col+BLK_W > MAP_COLS, or row+BLK_H > MAP_ROWS.
  - Opcode 11 is always invalid.
- Invalid command: state goes to ERR for one cycle with err_o=1, ram_we_o=0 and cmd_ready_o=0, then returns to IDLE. done_o is not asserted.
- WRITE: one write of cmd_data_i to cmd_addr_i.
- FILL: 300 writes of cmd_data_i to addresses 0,1,...,299 in ascending order. The address counter stops at 299 and does not wrap.
- BLOCK: BLK_W*BLK_H writes in row-major order, r outer and c inner.
  - Address = cmd_addr_i + r*MAP_COLS + c.
  - Data = (cmd_data_i + r*BLK_W + c) mod 2^RAM_DATA_WIDTH, so the tile type wraps silently.
  - The row step is an add of MAP_COLS-BLK_W+1 at the end of each row; no multipliers.
- ram_addr_o and ram_data_o hold their last values when ram_we_o=0.
- done_o and err_o are never high in the same cycle.
- Reset mid-command: the command is aborted with no further writes and no done_o. After rst_ni rises, cmd_ready_o is 1 in the first cycle.

Test Plan:
1. WRITE addr 5, data 7'h12 -> next cycle ram_we_o=1, ram_addr_o=5, ram_data_o=7'h12, done_o=1; cmd_ready_o low exactly 1 cycle.
2. FILL data 7'h03 -> 300 consecutive writes to addresses 0..299, all data 7'h03; done_o only with addr 299; cmd_ready_o low exactly 300 cycles.
3. BLOCK addr 21, base 10 -> 16 writes:
   - addresses 21-24, 41-44, 61-64, 81-84;
   - data 10..25 in order;
   - done_o on addr 84.
   Repeat with base 7'h7E -> data wraps to 7'h7E, 7'h7F, 0, 1, ...
4. Rejections, each giving one err_o pulse, no ram_we_o and 1 cycle ready-low:
   - BLOCK addr 17 (col 17);
   - BLOCK addr 240 (row 12);
   - WRITE addr 300;
   - opcode 11.
5. Assert rst_ni=0 during FILL after the 100th write -> ram_we_o=0 from the next cycle. After release, cmd_ready_o=1 immediately, and WRITE addr 0 data 1 completes normally.
6. Hold cmd_valid_i high with changing inputs during a BLOCK -> no acceptance while busy. The next command is accepted on the first ready cycle, and its first write follows in the next cycle.
